// File: rtl/riscv_pkg.sv
// Shared core types: access-size encoding plus the memory arbiter's state,
// owner and timeout-data definitions.
package riscv_pkg;

   typedef enum logic [1:0] {
      Byte_Access     = 2'b00,
      Halfword_Access = 2'b01,
      Word_Access     = 2'b10
   } access_size_e;

   typedef enum logic [1:0] {
      IDLE     = 2'b00,
      REQ      = 2'b01,
      WAIT_RSP = 2'b10
   } arb_state_e;

   typedef enum logic {
      OWNER_INSTR = 1'b0,
      OWNER_DATA  = 1'b1
   } arb_owner_e;

   localparam logic [31:0] MEM_TIMEOUT_RDATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/riscv_arb_starve_ctr.sv
// Saturating count of cycles a pending fetch has been passed over; raises
// fetch_prio once the count reaches MAX_STARVE.
module riscv_arb_starve_ctr #(
   parameter int MAX_STARVE = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic instr_req,
   input  logic instr_gnt,
   output logic fetch_prio
);

   localparam int CW = $clog2(MAX_STARVE + 1);
   localparam logic [CW-1:0] MAX_Q = CW'(MAX_STARVE);

   logic [CW-1:0] starve_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         starve_q <= '0;
      end else if (!instr_req || instr_gnt) begin
         starve_q <= '0;
      end else if (starve_q != MAX_Q) begin
         starve_q <= starve_q + 1'b1;
      end
   end

   assign fetch_prio = (starve_q >= MAX_Q);

endmodule

// File: rtl/riscv_mem_arbiter.sv
// Arbitrates fetch and load/store ports onto one single-port memory, one
// outstanding transaction at a time. MEM_TIMEOUT_EN adds a response watchdog.
module riscv_mem_arbiter
   import riscv_pkg::*;
#(
   parameter int MAX_STARVE     = 4,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        instr_req_i,
   input  logic [31:0] instr_addr_i,
   output logic        instr_gnt_o,
   output logic        instr_rvalid_o,
   output logic [31:0] instr_rdata_o,
   input  logic        data_req_i,
   input  logic [31:0] data_addr_i,
   input  logic [1:0]  data_byte_en_i,
   input  logic        data_wr_i,
   input  logic [31:0] data_wr_data_i,
   output logic        data_gnt_o,
   output logic        data_rvalid_o,
   output logic [31:0] data_rdata_o,
   output logic        mem_req_o,
   output logic [31:0] mem_addr_o,
   output logic [1:0]  mem_byte_en_o,
   output logic        mem_wr_o,
   output logic [31:0] mem_wr_data_o,
`ifdef MEM_TIMEOUT_EN
   output logic        mem_timeout_o,
`endif
   input  logic        mem_gnt_i,
   input  logic        mem_rvalid_i,
   input  logic [31:0] mem_rdata_i
);

   if (MAX_STARVE < 1 || TIMEOUT_CYCLES < 1) begin : g_param_check
      $error("riscv_mem_arbiter: MAX_STARVE and TIMEOUT_CYCLES must be >= 1");
   end

   arb_state_e state_q, state_next;
   arb_owner_e owner_q, owner_next;
   arb_owner_e sel_owner;
   logic       fetch_prio;
   logic       timeout_hit;
   logic       rsp_done;

   riscv_arb_starve_ctr #(
      .MAX_STARVE(MAX_STARVE)
   ) u_starve (
      .clk       (clk),
      .reset     (reset),
      .instr_req (instr_req_i),
      .instr_gnt (instr_gnt_o),
      .fetch_prio(fetch_prio)
   );

   // In IDLE the winner is picked live; afterwards the latched owner holds
   // the bus so a late data request cannot steal a locked fetch.
   always_comb begin
      sel_owner = owner_q;
      if (state_q == IDLE) begin
         sel_owner = (instr_req_i && (!data_req_i || fetch_prio)) ? OWNER_INSTR : OWNER_DATA;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         owner_q <= OWNER_INSTR;
      end else begin
         state_q <= state_next;
         owner_q <= owner_next;
      end
   end

`ifdef MEM_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

   logic [TW-1:0] to_cnt_q;

   // Held at zero outside WAIT_RSP, so every response wait starts from zero.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         to_cnt_q <= '0;
      end else if (state_q == WAIT_RSP) begin
         to_cnt_q <= to_cnt_q + 1'b1;
      end else begin
         to_cnt_q <= '0;
      end
   end

   assign timeout_hit   = (state_q == WAIT_RSP) && !mem_rvalid_i && (to_cnt_q == TO_LAST);
   assign mem_timeout_o = timeout_hit;
`else
   assign timeout_hit = 1'b0;
`endif

   assign rsp_done = mem_rvalid_i || timeout_hit;

   always_comb begin
      state_next     = state_q;
      owner_next     = owner_q;
      mem_req_o      = 1'b0;
      instr_gnt_o    = 1'b0;
      data_gnt_o     = 1'b0;
      instr_rvalid_o = 1'b0;
      data_rvalid_o  = 1'b0;
      case (state_q)
         IDLE: begin
            if (instr_req_i || data_req_i) begin
               mem_req_o  = 1'b1;
               owner_next = sel_owner;
               if (mem_gnt_i) begin
                  instr_gnt_o = (sel_owner == OWNER_INSTR);
                  data_gnt_o  = (sel_owner == OWNER_DATA);
                  state_next  = WAIT_RSP;
               end else begin
                  state_next  = REQ;
               end
            end
         end
         REQ: begin
            mem_req_o = 1'b1;
            if (mem_gnt_i) begin
               instr_gnt_o = (owner_q == OWNER_INSTR);
               data_gnt_o  = (owner_q == OWNER_DATA);
               state_next  = WAIT_RSP;
            end
         end
         WAIT_RSP: begin
            if (rsp_done) begin
               instr_rvalid_o = (owner_q == OWNER_INSTR);
               data_rvalid_o  = (owner_q == OWNER_DATA);
               state_next     = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // Request fields are zeroed whenever no request is presented.
   always_comb begin
      mem_addr_o    = '0;
      mem_byte_en_o = '0;
      mem_wr_o      = 1'b0;
      mem_wr_data_o = '0;
      if (mem_req_o) begin
         if (sel_owner == OWNER_INSTR) begin
            mem_addr_o    = instr_addr_i;
            mem_byte_en_o = Word_Access;
         end else begin
            mem_addr_o    = data_addr_i;
            mem_byte_en_o = data_byte_en_i;
            mem_wr_o      = data_wr_i;
            mem_wr_data_o = data_wr_data_i;
         end
      end
   end

   assign instr_rdata_o = timeout_hit ? MEM_TIMEOUT_RDATA : mem_rdata_i;
   assign data_rdata_o  = timeout_hit ? MEM_TIMEOUT_RDATA : mem_rdata_i;

endmodule

// File: tb/tb_riscv_mem_arbiter.sv
// Directed bench for riscv_mem_arbiter; the watchdog scenario runs only when
// MEM_TIMEOUT_EN is defined.
module tb_riscv_mem_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic        instr_req_i;
   logic [31:0] instr_addr_i;
   logic        instr_gnt_o;
   logic        instr_rvalid_o;
   logic [31:0] instr_rdata_o;
   logic        data_req_i;
   logic [31:0] data_addr_i;
   logic [1:0]  data_byte_en_i;
   logic        data_wr_i;
   logic [31:0] data_wr_data_i;
   logic        data_gnt_o;
   logic        data_rvalid_o;
   logic [31:0] data_rdata_o;
   logic        mem_req_o;
   logic [31:0] mem_addr_o;
   logic [1:0]  mem_byte_en_o;
   logic        mem_wr_o;
   logic [31:0] mem_wr_data_o;
`ifdef MEM_TIMEOUT_EN
   logic        mem_timeout_o;
`endif
   logic        mem_gnt_i;
   logic        mem_rvalid_i;
   logic [31:0] mem_rdata_i;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   riscv_mem_arbiter #(
      .MAX_STARVE    (4),
      .TIMEOUT_CYCLES(8)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .instr_req_i   (instr_req_i),
      .instr_addr_i  (instr_addr_i),
      .instr_gnt_o   (instr_gnt_o),
      .instr_rvalid_o(instr_rvalid_o),
      .instr_rdata_o (instr_rdata_o),
      .data_req_i    (data_req_i),
      .data_addr_i   (data_addr_i),
      .data_byte_en_i(data_byte_en_i),
      .data_wr_i     (data_wr_i),
      .data_wr_data_i(data_wr_data_i),
      .data_gnt_o    (data_gnt_o),
      .data_rvalid_o (data_rvalid_o),
      .data_rdata_o  (data_rdata_o),
      .mem_req_o     (mem_req_o),
      .mem_addr_o    (mem_addr_o),
      .mem_byte_en_o (mem_byte_en_o),
      .mem_wr_o      (mem_wr_o),
      .mem_wr_data_o (mem_wr_data_o),
`ifdef MEM_TIMEOUT_EN
      .mem_timeout_o (mem_timeout_o),
`endif
      .mem_gnt_i     (mem_gnt_i),
      .mem_rvalid_i  (mem_rvalid_i),
      .mem_rdata_i   (mem_rdata_i)
   );

   // Inputs change 1 time unit after the rising edge; checks run 2 units later.
   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      instr_req_i = 0; instr_addr_i = '0;
      data_req_i = 0; data_addr_i = '0; data_byte_en_i = 2'b10; data_wr_i = 0; data_wr_data_i = '0;
      mem_gnt_i = 0; mem_rvalid_i = 0; mem_rdata_i = '0;
   endtask

   task automatic test_reset();
      idle_inputs();
      reset = 1;
      repeat (2) next_cycle();
      #2;
      checks++;
      if ({instr_gnt_o, data_gnt_o, instr_rvalid_o, data_rvalid_o, mem_req_o} !== 5'b0) begin
         failures++;
         $display("FAIL reset_outputs: got %b expected 00000", {instr_gnt_o, data_gnt_o, instr_rvalid_o, data_rvalid_o, mem_req_o});
      end
      checks++;
      if ({mem_addr_o, mem_byte_en_o, mem_wr_o, mem_wr_data_o} !== 67'b0) begin
         failures++;
         $display("FAIL reset_mem_fields: got addr=%h be=%b wr=%b wd=%h expected all 0", mem_addr_o, mem_byte_en_o, mem_wr_o, mem_wr_data_o);
      end
      next_cycle();
      reset = 0;
      $display("reset released");
   endtask

   task automatic test_fetch_only();
      next_cycle();
      instr_req_i = 1; instr_addr_i = 32'h100; mem_gnt_i = 1;
      #2;
      checks++;
      if ({instr_gnt_o, data_gnt_o, mem_req_o, mem_wr_o, mem_byte_en_o} !== 6'b101010 || mem_addr_o !== 32'h100) begin
         failures++;
         $display("FAIL fetch_grant: got gnt=%b/%b req=%b wr=%b be=%b addr=%h expected 1/0 1 0 10 00000100",
                  instr_gnt_o, data_gnt_o, mem_req_o, mem_wr_o, mem_byte_en_o, mem_addr_o);
      end
      next_cycle();
      instr_req_i = 0; mem_gnt_i = 0;
      #2;
      checks++;
      if ({mem_req_o, instr_rvalid_o, data_rvalid_o} !== 3'b000) begin
         failures++;
         $display("FAIL fetch_wait: got req=%b rv=%b/%b expected 0 0/0", mem_req_o, instr_rvalid_o, data_rvalid_o);
      end
      next_cycle();
      mem_rvalid_i = 1; mem_rdata_i = 32'h00A0_0093;
      #2;
      checks++;
      if ({instr_rvalid_o, data_rvalid_o} !== 2'b10 || instr_rdata_o !== 32'h00A0_0093) begin
         failures++;
         $display("FAIL fetch_rvalid: got rv=%b/%b rdata=%h expected 1/0 00a00093", instr_rvalid_o, data_rvalid_o, instr_rdata_o);
      end
      $display("fetch addr=00000100 rdata=%h", instr_rdata_o);
      next_cycle();
      idle_inputs();
   endtask

   task automatic test_data_priority();
      next_cycle();
      instr_req_i = 1; instr_addr_i = 32'h104;
      data_req_i = 1; data_addr_i = 32'h200; data_byte_en_i = 2'b01; data_wr_i = 1; data_wr_data_i = 32'h1234_5678;
      mem_gnt_i = 1;
      #2;
      checks++;
      if ({data_gnt_o, instr_gnt_o, mem_wr_o, mem_byte_en_o} !== 5'b10101 || mem_addr_o !== 32'h200 || mem_wr_data_o !== 32'h1234_5678) begin
         failures++;
         $display("FAIL both_data_first: got gnt=%b/%b wr=%b be=%b addr=%h wd=%h expected d1/i0 1 01 00000200 12345678",
                  data_gnt_o, instr_gnt_o, mem_wr_o, mem_byte_en_o, mem_addr_o, mem_wr_data_o);
      end
      next_cycle();
      data_req_i = 0; mem_gnt_i = 0;
      #2;
      checks++;
      if ({instr_gnt_o, mem_req_o} !== 2'b00) begin
         failures++;
         $display("FAIL both_fetch_waits: got gnt=%b req=%b expected 0 0", instr_gnt_o, mem_req_o);
      end
      next_cycle();
      mem_rvalid_i = 1; mem_rdata_i = 32'h0;
      #2;
      checks++;
      if ({data_rvalid_o, instr_rvalid_o} !== 2'b10) begin
         failures++;
         $display("FAIL both_store_ack: got rv=%b/%b expected d1/i0", data_rvalid_o, instr_rvalid_o);
      end
      next_cycle();
      mem_rvalid_i = 0; mem_gnt_i = 1;
      #2;
      checks++;
      if ({instr_gnt_o, data_gnt_o} !== 2'b10 || mem_addr_o !== 32'h104 || mem_byte_en_o !== 2'b10) begin
         failures++;
         $display("FAIL both_fetch_after: got gnt=%b/%b addr=%h be=%b expected 1/0 00000104 10", instr_gnt_o, data_gnt_o, mem_addr_o, mem_byte_en_o);
      end
      $display("store addr=00000200 then fetch addr=00000104");
      next_cycle();
      instr_req_i = 0; mem_gnt_i = 0; mem_rvalid_i = 1;
      next_cycle();
      idle_inputs();
   endtask

   task automatic test_starvation();
      int data_wins = 0;
      int fetch_cycle = -1;
      next_cycle();
      instr_req_i = 1; instr_addr_i = 32'h108;
      data_req_i = 1; data_addr_i = 32'h240; data_byte_en_i = 2'b10; data_wr_i = 0;
      mem_gnt_i = 1; mem_rvalid_i = 1; mem_rdata_i = 32'h5555_AAAA;
      for (int c = 0; c < 20 && fetch_cycle < 0; c++) begin
         if (c != 0) next_cycle();
         #2;
         if (data_gnt_o) data_wins++;
         if (instr_gnt_o) fetch_cycle = c;
      end
      checks++;
      if (fetch_cycle !== 4) begin
         failures++;
         $display("FAIL starve_fetch_cycle: got %0d expected 4", fetch_cycle);
      end
      checks++;
      if (data_wins !== 2) begin
         failures++;
         $display("FAIL starve_data_wins: got %0d expected 2 (limit 4)", data_wins);
      end
      next_cycle();
      instr_req_i = 0; data_req_i = 0; mem_gnt_i = 0;
      #2;
      checks++;
      if ({instr_rvalid_o, data_rvalid_o} !== 2'b10 || instr_rdata_o !== 32'h5555_AAAA) begin
         failures++;
         $display("FAIL starve_fetch_rsp: got rv=%b/%b rdata=%h expected 1/0 5555aaaa", instr_rvalid_o, data_rvalid_o, instr_rdata_o);
      end
      $display("starvation: %0d data wins, fetch at cycle %0d", data_wins, fetch_cycle);
      next_cycle();
      idle_inputs();
   endtask

   task automatic test_req_lock();
      next_cycle();
      instr_req_i = 1; instr_addr_i = 32'h300; mem_gnt_i = 0;
      #2;
      checks++;
      if ({mem_req_o, instr_gnt_o} !== 2'b10 || mem_addr_o !== 32'h300) begin
         failures++;
         $display("FAIL lock_c0: got req=%b gnt=%b addr=%h expected 1 0 00000300", mem_req_o, instr_gnt_o, mem_addr_o);
      end
      for (int c = 1; c <= 2; c++) begin
         next_cycle();
         data_req_i = 1; data_addr_i = 32'h400;
         #2;
         checks++;
         if ({mem_req_o, instr_gnt_o, data_gnt_o} !== 3'b100 || mem_addr_o !== 32'h300) begin
            failures++;
            $display("FAIL lock_c%0d: got req=%b gnt=%b/%b addr=%h expected 1 0/0 00000300", c, mem_req_o, instr_gnt_o, data_gnt_o, mem_addr_o);
         end
      end
      next_cycle();
      mem_gnt_i = 1;
      #2;
      checks++;
      if ({instr_gnt_o, data_gnt_o} !== 2'b10 || mem_addr_o !== 32'h300) begin
         failures++;
         $display("FAIL lock_c3_grant: got gnt=%b/%b addr=%h expected 1/0 00000300", instr_gnt_o, data_gnt_o, mem_addr_o);
      end
      $display("locked fetch addr=00000300 granted at cycle 3");
      next_cycle();
      instr_req_i = 0; data_req_i = 0; mem_gnt_i = 0; mem_rvalid_i = 1;
      next_cycle();
      idle_inputs();
   endtask

   task automatic test_reset_mid();
      next_cycle();
      instr_req_i = 1; instr_addr_i = 32'h500; mem_gnt_i = 1;
      next_cycle();
      idle_inputs();
      reset = 1;
      #2;
      checks++;
      if ({mem_req_o, instr_rvalid_o, data_rvalid_o} !== 3'b000) begin
         failures++;
         $display("FAIL rstmid_during: got req=%b rv=%b/%b expected 0 0/0", mem_req_o, instr_rvalid_o, data_rvalid_o);
      end
      next_cycle();
      reset = 0; mem_rvalid_i = 1; mem_rdata_i = 32'hCAFE_0001;
      #2;
      checks++;
      if ({mem_req_o, instr_rvalid_o, data_rvalid_o} !== 3'b000) begin
         failures++;
         $display("FAIL rstmid_dropped: got req=%b rv=%b/%b expected 0 0/0", mem_req_o, instr_rvalid_o, data_rvalid_o);
      end
      next_cycle();
      mem_rvalid_i = 0; instr_req_i = 1; instr_addr_i = 32'h600; mem_gnt_i = 1;
      #2;
      checks++;
      if (instr_gnt_o !== 1'b1 || mem_addr_o !== 32'h600) begin
         failures++;
         $display("FAIL rstmid_idle: got gnt=%b addr=%h expected 1 00000600", instr_gnt_o, mem_addr_o);
      end
      $display("reset mid-transaction, response dropped, fetch addr=00000600 issued");
      next_cycle();
      instr_req_i = 0; mem_gnt_i = 0; mem_rvalid_i = 1;
      next_cycle();
      idle_inputs();
   endtask

`ifdef MEM_TIMEOUT_EN
   task automatic test_timeout();
      next_cycle();
      instr_req_i = 1; instr_addr_i = 32'h700; mem_gnt_i = 1;
      next_cycle();
      idle_inputs();
      mem_rdata_i = 32'h1111_2222;
      for (int k = 1; k <= 8; k++) begin
         if (k != 1) next_cycle();
         #2;
         checks++;
         if (mem_timeout_o !== (k == 8) || instr_rvalid_o !== (k == 8)) begin
            failures++;
            $display("FAIL timeout_c%0d: got to=%b rv=%b expected %b", k, mem_timeout_o, instr_rvalid_o, (k == 8));
         end
         if (k == 8) begin
            checks++;
            if (instr_rdata_o !== 32'hDEAD_BEEF) begin
               failures++;
               $display("FAIL timeout_rdata: got %h expected deadbeef", instr_rdata_o);
            end
         end
      end
      $display("fetch addr=00000700 timed out");
      next_cycle();
      idle_inputs();
   endtask
`endif

   initial begin
      test_reset();
      test_fetch_only();
      test_data_priority();
      test_starvation();
      test_req_lock();
      test_reset_mid();
`ifdef MEM_TIMEOUT_EN
      test_timeout();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/riscv_mem_arbiter.md
Name: riscv_mem_arbiter

Overview:
- Shares one single-port memory between the instruction-fetch port and the load/store data port of the core.
- Sits between the fetch unit and the data memory interface on one side, and the unified memory on the other.
- Request/grant/response protocol with one outstanding transaction at a time.
- Data-first priority, with a starvation counter that guarantees forward progress for fetch.

Parameters:
- MAX_STARVE, 4: consecutive cycles a pending fetch may lose before it gets priority (>=1).
- TIMEOUT_CYCLES, 64: response watchdog limit; used only under MEM_TIMEOUT_EN.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- instr_req_i  in  1  fetch request; held with stable fields until granted
- instr_addr_i  in  32  fetch address (word read, byte_en forced to Word_Access)
- instr_gnt_o  out  1  fetch request accepted this cycle
- instr_rvalid_o  out  1  fetch response valid
- instr_rdata_o  out  32  fetch read data
- data_req_i  in  1  load/store request; held stable until granted
- data_addr_i  in  32  load/store address
- data_byte_en_i  in  2  access size (riscv_pkg encoding)
- data_wr_i  in  1  1=store
- data_wr_data_i  in  32  store data
- data_gnt_o  out  1  data request accepted
- data_rvalid_o  out  1  data response valid (also acks stores)
- data_rdata_o  out  32  load data
- mem_req_o  out  1  request to memory
- mem_addr_o  out  32  memory address
- mem_byte_en_o  out  2  memory access size
- mem_wr_o  out  1  memory write enable
- mem_wr_data_o  out  32  memory write data
- mem_gnt_i  in  1  memory accepted mem_req_o this cycle
- mem_rvalid_i  in  1  memory response for the accepted request
- mem_rdata_i  in  32  memory read data
- mem_timeout_o  out  1  watchdog pulse (present only under MEM_TIMEOUT_EN)

Behaviour:
- FSM states: IDLE, REQ (winner locked, awaiting mem_gnt_i), WAIT_RSP.
- Reset: state IDLE, owner cleared, lock cleared, starve counter 0.
  - All gnt_o, rvalid_o and mem_req_o are 0.
  - mem_* fields are 0 whenever mem_req_o=0.
- IDLE:
  - If any req_i is high, select the winner combinationally and drive mem_req_o=1 with the winner's fields the same cycle.
  - If mem_gnt_i=1 that cycle: winner gnt_o=1, owner latched, go to WAIT_RSP.
  - Otherwise latch the winner and go to REQ.
- REQ:
  - The winner stays selected (no switching, even if the other port asserts).
  - mem_req_o=1 until mem_gnt_i; then gnt_o to the owner and go to WAIT_RSP.
- WAIT_RSP:
  - mem_req_o=0.
  - On mem_rvalid_i: the owner's rvalid_o=1 combinationally in the same cycle; go to IDLE.
- Next request issues at the earliest in the cycle after rvalid. Best case is one transaction per 2 cycles.
- rdata_o on both ports = mem_rdata_i, qualified only by the respective rvalid_o.
- mem_rvalid_i is ignored in IDLE and REQ (no owner).
- Priority:
  - Data wins, unless starve_q >= MAX_STARVE, in which case fetch wins.
  - starve_q increments each cycle instr_req_i=1 and instr_gnt_o=0, saturating at MAX_STARVE.
  - starve_q clears on instr_gnt_o or when instr_req_i=0.
  - Counter width: $clog2(MAX_STARVE+1).
- Fetch transactions drive mem_wr_o=0, mem_wr_data_o=0 and mem_byte_en_o=Word_Access.
- Reset asserted mid-transaction: return to IDLE immediately; the in-flight response is dropped and no rvalid is issued.

Optional Feature:
- MEM_TIMEOUT_EN defined:
  - A counter runs in WAIT_RSP.
  - If TIMEOUT_CYCLES elapse without mem_rvalid_i: one-cycle mem_timeout_o=1, the owner's rvalid_o=1 with rdata 32'hDEAD_BEEF, return to IDLE.
  - Counter clears on entry to WAIT_RSP.
- Not defined: no counter and no mem_timeout_o port; WAIT_RSP waits indefinitely.

Decomposition:
- Add to riscv_pkg:
  - arb_state_e enum (IDLE, REQ, WAIT_RSP).
  - arb_owner_e enum (OWNER_INSTR, OWNER_DATA).
  - MEM_TIMEOUT_RDATA constant 32'hDEAD_BEEF.
- Reuse the existing access-size enum (Byte_Access/Halfword_Access/Word_Access).
- One sub-module: riscv_arb_starve_ctr (saturating starvation counter, outputs the fetch-priority flag).

Test Plan:
- Fetch only, addr 0x100, mem_gnt_i same cycle, rvalid 2 cycles later with 0x00A00093 -> instr_gnt_o at cycle 0, instr_rvalid_o with 0x00A00093 at cycle 2, data_rvalid_o stays 0.
- Both req at once, MAX_STARVE=4, data store 0x200/0x12345678 -> data granted first, mem_wr_o=1, mem_byte_en_o=data_byte_en_i; fetch granted after data rvalid.
- data_req_i held high continuously with fetch pending -> fetch granted once starve_q reaches 4; no more than 4 consecutive data wins.
- mem_gnt_i held low 3 cycles while data_req_i rises during REQ owned by fetch -> mem_addr_o stays the fetch address; fetch granted on cycle 3.
- Reset pulsed during WAIT_RSP, then mem_rvalid_i=1 -> no rvalid_o on either port, state IDLE, mem_req_o=0.
- MEM_TIMEOUT_EN, TIMEOUT_CYCLES=8, no rvalid -> mem_timeout_o pulse on cycle 8 of WAIT_RSP, owner rvalid_o=1 with 0xDEADBEEF.
